// File: rtl/exec_int_pipe.sv
// rtl/exec_int_pipe.sv - integer execution stage with in-order result FIFO
module exec_int_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       flush,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [3:0]                 issue_op,
  input  logic [XLEN-1:0]            issue_rs1,
  input  logic [XLEN-1:0]            issue_rs2,
  input  logic [TAGW-1:0]            issue_rd,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [XLEN-1:0]            res_data,
  output logic [TAGW-1:0]            res_rd,
  output logic                       res_wen,
  output logic                       res_illegal,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [31:0]                retired_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SHW = $clog2(XLEN);
  localparam int ENW = XLEN + TAGW + 2;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ENW-1:0]  mem_q [DEPTH];
  logic [ENW-1:0]  mem_d [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [31:0]     retired_cnt_q, retired_cnt_d;
  logic            ready_q, ready_d;

  logic [XLEN-1:0] alu_data;
  logic            alu_legal;
  logic            alu_wen;
  logic [SHW-1:0]  shamt;
  logic            push;
  logic            pop;
  logic [ENW-1:0]  head;

  assign shamt = issue_rs2[SHW-1:0];

  always_comb begin
    alu_data  = '0;
    alu_legal = 1'b1;
    case (issue_op)
      OP_NOP:  alu_data = '0;
      OP_ADD:  alu_data = issue_rs1 + issue_rs2;
      OP_SUB:  alu_data = issue_rs1 - issue_rs2;
      OP_AND:  alu_data = issue_rs1 & issue_rs2;
      OP_OR:   alu_data = issue_rs1 | issue_rs2;
      OP_XOR:  alu_data = issue_rs1 ^ issue_rs2;
      OP_SLL:  alu_data = issue_rs1 << shamt;
      OP_SRL:  alu_data = issue_rs1 >> shamt;
      OP_SRA:  alu_data = $unsigned($signed(issue_rs1) >>> shamt);
      OP_SLT:  alu_data = {{(XLEN-1){1'b0}}, ($signed(issue_rs1) < $signed(issue_rs2))};
      OP_SLTU: alu_data = {{(XLEN-1){1'b0}}, (issue_rs1 < issue_rs2)};
      default: alu_legal = 1'b0;
    endcase
    // writes to x0 are architecturally discarded, so never request them
    alu_wen = alu_legal && (issue_op != OP_NOP) && (issue_rd != '0);
  end

  assign occupancy   = wr_ptr_q - rd_ptr_q;
  assign res_valid   = (occupancy != '0);
  assign issue_ready = ready_q && (occupancy != FULL_CNT);
  assign push        = issue_valid && issue_ready && !flush;
  assign pop         = res_valid && res_ready;

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign res_data    = head[XLEN-1:0];
  assign res_rd      = head[XLEN+TAGW-1:XLEN];
  assign res_wen     = head[XLEN+TAGW];
  assign res_illegal = head[XLEN+TAGW+1];
  assign retired_cnt = retired_cnt_q;

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    retired_cnt_d = retired_cnt_q;
    ready_d       = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = {!alu_legal, alu_wen, issue_rd, alu_data};
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_d      = rd_ptr_q + (AW+1)'(1);
        retired_cnt_d = retired_cnt_q + 32'd1;
      end
    end
  end

  // ready_q holds issue off until the first edge after reset releases
  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      retired_cnt_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      retired_cnt_q <= retired_cnt_d;
      ready_q       <= ready_d;
    end
  end

endmodule

// File: tb/tb_exec_int_pipe.sv
// tb/tb_exec_int_pipe.sv - directed self-checking bench for exec_int_pipe
module tb_exec_int_pipe;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [4:0]  issue_rd;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_wen;
  logic        res_illegal;
  logic [2:0]  occupancy;
  logic [31:0] retired_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_ret = 32'd0;

  exec_int_pipe #(.XLEN(32), .DEPTH(4), .TAGW(5)) dut (
    .clk(clk), .rst_l(rst_l), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_wen(res_wen), .res_illegal(res_illegal),
    .occupancy(occupancy), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    issue_valid = 1'b1; issue_op = op; issue_rs1 = a; issue_rs2 = b; issue_rd = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic pop_one();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_ret = exp_ret + 32'd1;
  endtask

  task automatic test_reset();
    rst_l = 1'b1; flush = 1'b0; issue_valid = 1'b0; res_ready = 1'b0;
    issue_op = 4'd0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    #12;
    n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", issue_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", res_valid); end
    n_cmp++; if ({res_data, res_rd, res_wen, res_illegal} !== 39'd0) begin n_bad++; $display("FAIL rst_res: got %h/%h/%b/%b want zeros", res_data, res_rd, res_wen, res_illegal); end
    n_cmp++; if (occupancy !== 3'd0 || retired_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_counts: got occ %0d ret %0d want 0 0", occupancy, retired_cnt); end
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL rel_ready_pre_edge: got %b want 0", issue_ready); end
    tick();
    n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready_post_edge: got %b want 1", issue_ready); end
  endtask

  task automatic test_add_li();
    issue(4'd1, 32'hFFFF_FFFF, 32'd1, 5'd5);
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", res_valid); end
    n_cmp++; if (res_data !== 32'd0 || res_rd !== 5'd5 || res_wen !== 1'b1) begin n_bad++; $display("FAIL add_res: got %h rd %0d wen %b want 0 rd 5 wen 1", res_data, res_rd, res_wen); end
    pop_one();
    issue(4'd1, 32'd0, 32'h123, 5'd0);
    n_cmp++; if (res_data !== 32'h123 || res_wen !== 1'b0) begin n_bad++; $display("FAIL li_x0: got %h wen %b want 123 wen 0", res_data, res_wen); end
    pop_one();
    n_cmp++; if (retired_cnt !== exp_ret) begin n_bad++; $display("FAIL add_retired: got %0d want %0d", retired_cnt, exp_ret); end
  endtask

  task automatic test_full_backpressure();
    for (int i = 1; i <= 4; i++) issue(4'd1, 32'(i), 32'd10, 5'(i));
    n_cmp++; if (occupancy !== 3'd4 || issue_ready !== 1'b0) begin n_bad++; $display("FAIL full_state: got occ %0d ready %b want 4 0", occupancy, issue_ready); end
    issue_valid = 1'b1; issue_op = 4'd1; issue_rs1 = 32'd99; issue_rs2 = 32'd0; issue_rd = 5'd9;
    res_ready = 1'b1;
    tick();
    issue_valid = 1'b0;
    exp_ret = exp_ret + 32'd1;
    n_cmp++; if (occupancy !== 3'd3) begin n_bad++; $display("FAIL full_pop_no_push: got occ %0d want 3", occupancy); end
    for (int k = 2; k <= 4; k++) begin
      n_cmp++; if (res_valid !== 1'b1 || res_data !== 32'(10 + k) || res_rd !== 5'(k)) begin n_bad++; $display("FAIL drain_order_%0d: got v %b %0d rd %0d want 1 %0d rd %0d", k, res_valid, res_data, res_rd, 10 + k, k); end
      tick();
      exp_ret = exp_ret + 32'd1;
    end
    res_ready = 1'b0;
    n_cmp++; if (occupancy !== 3'd0 || res_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got occ %0d v %b want 0 0", occupancy, res_valid); end
    n_cmp++; if (retired_cnt !== exp_ret) begin n_bad++; $display("FAIL drain_retired: got %0d want %0d", retired_cnt, exp_ret); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  t_op  [11] = '{4'd8, 4'd9, 4'd10, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd13, 4'd0};
    logic [31:0] t_a   [11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hF0F0, 32'hF0F0, 32'hFF00, 32'd1, 32'h8000_0000, 32'd5, 32'd5};
    logic [31:0] t_b   [11] = '{32'h24, 32'd1, 32'd1, 32'd7, 32'hFF00, 32'h0F00, 32'h0FF0, 32'h21, 32'd31, 32'd5, 32'd5};
    logic [31:0] t_res [11] = '{32'hF800_0000, 32'd1, 32'd0, 32'hFFFF_FFFE, 32'hF000, 32'hFFF0, 32'hF0F0, 32'd2, 32'd1, 32'd0, 32'd0};
    logic        t_wen [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        t_ill [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 5'd3);
      n_cmp++; if (res_valid !== 1'b1 || res_data !== t_res[i] || res_wen !== t_wen[i] || res_illegal !== t_ill[i]) begin n_bad++; $display("FAIL alu_op%0d: got v %b %h wen %b ill %b want 1 %h wen %b ill %b", t_op[i], res_valid, res_data, res_wen, res_illegal, t_res[i], t_wen[i], t_ill[i]); end
      pop_one();
      n_cmp++; if (retired_cnt !== exp_ret) begin n_bad++; $display("FAIL alu_retired_op%0d: got %0d want %0d", t_op[i], retired_cnt, exp_ret); end
    end
  endtask

  task automatic test_flush();
    issue(4'd1, 32'd1, 32'd1, 5'd1);
    issue(4'd1, 32'd2, 32'd2, 5'd2);
    n_cmp++; if (occupancy !== 3'd2) begin n_bad++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
    issue_valid = 1'b1; issue_op = 4'd1; issue_rs1 = 32'd7; issue_rs2 = 32'd7; issue_rd = 5'd7;
    res_ready = 1'b1; flush = 1'b1;
    tick();
    issue_valid = 1'b0; res_ready = 1'b0; flush = 1'b0;
    n_cmp++; if (occupancy !== 3'd0 || res_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty: got occ %0d v %b want 0 0", occupancy, res_valid); end
    n_cmp++; if (retired_cnt !== exp_ret) begin n_bad++; $display("FAIL flush_retired: got %0d want %0d", retired_cnt, exp_ret); end
    tick();
    n_cmp++; if (occupancy !== 3'd0 || issue_ready !== 1'b1) begin n_bad++; $display("FAIL flush_after: got occ %0d ready %b want 0 1", occupancy, issue_ready); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) issue(4'd4, 32'(i), 32'h100, 5'd4);
    n_cmp++; if (occupancy !== 3'd3) begin n_bad++; $display("FAIL mid_pre_occ: got %0d want 3", occupancy); end
    #2;
    rst_l = 1'b1;
    #1;
    n_cmp++; if (occupancy !== 3'd0 || res_valid !== 1'b0 || issue_ready !== 1'b0) begin n_bad++; $display("FAIL mid_async: got occ %0d v %b ready %b want 0 0 0", occupancy, res_valid, issue_ready); end
    n_cmp++; if (retired_cnt !== 32'd0) begin n_bad++; $display("FAIL mid_retired: got %0d want 0", retired_cnt); end
    exp_ret = 32'd0;
    @(negedge clk);
    rst_l = 1'b0;
    tick();
    n_cmp++; if (issue_ready !== 1'b1 || occupancy !== 3'd0) begin n_bad++; $display("FAIL mid_release: got ready %b occ %0d want 1 0", issue_ready, occupancy); end
  endtask

  task automatic test_retired_wrap();
    @(negedge clk);
    force dut.retired_cnt_d = 32'hFFFF_FFFF;
    tick();
    release dut.retired_cnt_d;
    n_cmp++; if (retired_cnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want ffffffff", retired_cnt); end
    issue(4'd1, 32'd3, 32'd4, 5'd6);
    n_cmp++; if (res_data !== 32'd7) begin n_bad++; $display("FAIL wrap_data: got %0d want 7", res_data); end
    pop_one();
    n_cmp++; if (retired_cnt !== 32'd0) begin n_bad++; $display("FAIL wrap_rollover: got %h want 0", retired_cnt); end
  endtask

  initial begin
    test_reset();
    test_add_li();
    test_full_backpressure();
    test_alu_ops();
    test_flush();
    test_reset_mid();
    test_retired_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
